// File: rtl/imem_pkg.sv
// Shared constants and loader state type for the instruction memory and its
// boot-time loader, so both sides agree on geometry.
package imem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 13;
    localparam int WORD_NUM   = (2 ** ADDR_WIDTH) / 4;
    // Word index is one bit wider than a word address so that a full image
    // (N == WORD_NUM) can be counted without overflow.
    localparam int IDX_WIDTH  = ADDR_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer: a 2-bit lane counter steers each accepted
// byte into its lane and flags the byte that completes a word.
module byte_packer
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_fire,
    input  logic [7:0]            in_byte,
    output logic [DATA_WIDTH-1:0] word,
    output logic                  word_done
);

    logic [1:0]            lane_q, lane_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;

    // Word as it looks including the byte accepted this cycle, so the
    // complete word is available combinationally on the lane-3 byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign word[8*gi +: 8] = (in_fire && (lane_q == 2'(gi))) ? in_byte
                                                                 : acc_q[8*gi +: 8];
    end

    // Lane advance and partial-word capture.
    always_comb begin
        lane_d    = lane_q;
        acc_d     = acc_q;
        word_done = 1'b0;
        if (clr) begin
            lane_d = 2'd0;
            acc_d  = '0;
        end else if (in_fire) begin
            lane_d    = lane_q + 2'd1;
            acc_d     = word;
            word_done = (lane_q == 2'd3);
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= 2'd0;
            acc_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte stream, writes the
// payload words into instruction RAM and holds the CPU in reset until a
// verified image is in place.
module imem_loader
    import imem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  cpu_hold
);

    loader_state_t         state_q, state_d;
    logic [7:0]            len_lo_q, len_lo_d;
    logic [IDX_WIDTH-1:0]  n_q, n_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  w_en_q, w_en_d;
    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;

    logic                  fire;
    logic                  clr;
    logic [15:0]           len_full;
    logic [DATA_WIDTH-1:0] pk_word;
    logic                  pk_done;

    assign fire     = in_valid && in_ready;
    assign len_full = {in_data, len_lo_q};

    byte_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_fire   (fire && (state_q == DATA)),
        .in_byte   (in_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

    // Frame parser, word/checksum bookkeeping and write-port scheduling.
    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        clr      = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = LEN_LO;
                    clr      = 1'b1;
                    len_lo_d = 8'd0;
                    n_d      = '0;
                    idx_d    = '0;
                    csum_d   = 8'd0;
                end
            end
            LEN_LO: begin
                if (fire) begin
                    len_lo_d = in_data;
                    state_d  = LEN_HI;
                end
            end
            LEN_HI: begin
                if (fire) begin
                    if (len_full > 16'(WORD_NUM)) begin
                        state_d = ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = CSUM;
                    end else begin
                        n_d     = len_full[IDX_WIDTH-1:0];
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (fire) begin
                    csum_d = csum_q + in_data;
                    if (pk_done) begin
                        w_en_d   = 1'b1;
                        w_addr_d = {idx_q[IDX_WIDTH-2:0], 2'b00};
                        w_data_d = pk_word;
                        idx_d    = idx_q + 1'b1;
                        if (idx_d == n_q) begin
                            state_d = CSUM;
                        end
                    end
                end
            end
            CSUM: begin
                if (fire) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Loader state and write-port registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_lo_q <= 8'd0;
            n_q      <= '0;
            idx_q    <= '0;
            csum_q   <= 8'd0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy     = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                   (state_q == DATA)   || (state_q == CSUM);
        in_ready = busy;
        done     = (state_q == DONE);
        err      = (state_q == ERR);
        cpu_hold = (state_q != DONE);
        w_en     = w_en_q;
        w_addr   = w_addr_q;
        w_data   = w_data_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a frame-level model predicts the write list
// and final status; a monitor checks every write and status invariants.
module tb_imem_loader;
    import imem_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst, start, in_valid;
    logic [7:0]            in_data;
    logic                  in_ready, w_en, busy, done, err, cpu_hold;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_t;

    wr_t                   exp_q[$];
    int                    n_vec = 0;
    int                    n_bad = 0;
    logic                  chk_en = 1'b0;
    logic                  prev_wen = 1'b0;
    logic [ADDR_WIDTH-1:0] last_waddr = '0;
    logic [DATA_WIDTH-1:0] last_wdata = '0;

    imem_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .cpu_hold (cpu_hold)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] pay[$]);
        logic [7:0] s = 8'd0;
        foreach (pay[i]) s = s + pay[i];
        return s;
    endfunction

    // Monitor: every write must match the next predicted one; status invariants.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (chk_en) begin
            check("ready_vs_busy", {31'd0, in_ready}, {31'd0, busy});
            check("hold_vs_done", {31'd0, cpu_hold}, {31'd0, ~done});
            check("done_err_excl", {31'd0, done && err}, 32'd0);
            check("wen_single_cycle", {31'd0, w_en && prev_wen}, 32'd0);
            if (w_en) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_write: addr %h data %h, none expected", w_addr, w_data);
                end else begin
                    e = exp_q.pop_front();
                    check("w_addr", {19'd0, w_addr}, {19'd0, e.addr});
                    check("w_data", w_data, e.data);
                end
                last_waddr <= w_addr;
                last_wdata <= w_data;
            end
        end
        prev_wen <= w_en;
    end

    task automatic send(input logic [7:0] fr[$], input bit gap, input int start_at);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == start_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = fr[i];
            begin
                int g = 0;
                while (!in_ready && g < 50) begin
                    tick();
                    g++;
                end
                n_vec++;
                if (g >= 50) begin
                    n_bad++;
                    $display("FAIL ready_timeout: byte %0d in_ready stayed 0 required 1", i);
                end
            end
            tick();
            in_valid = 1'b0;
            if (gap) tick();
        end
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_start_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_start_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_start_done_clr"}, {31'd0, done || err}, 32'd0);
    endtask

    // Full load: predict writes and outcome from the frame, drive it, check.
    task automatic load(input logic [7:0] pay[$], input logic [7:0] csum,
                        input bit gap, input int start_at, input string tag);
        int         nw = pay.size() / 4;
        logic [7:0] fr[$];
        logic       good;
        good = (model_sum(pay) == csum);
        for (int w = 0; w < nw; w++)
            exp_q.push_back('{addr: ADDR_WIDTH'(4 * w),
                              data: {pay[4*w+3], pay[4*w+2], pay[4*w+1], pay[4*w]}});
        fr.push_back(nw[7:0]);
        fr.push_back(nw[15:8]);
        foreach (pay[i]) fr.push_back(pay[i]);
        fr.push_back(csum);
        do_start(tag);
        send(fr, gap, (start_at < 0) ? -1 : start_at + 2);
        check({tag, "_done"}, {31'd0, done}, {31'd0, good});
        check({tag, "_err"}, {31'd0, err}, {31'd0, ~good});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, ~good});
        check({tag, "_ready_off"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_writes_left"}, exp_q.size(), 32'd0);
    endtask

    initial begin : stim
        logic [7:0] p1[$];
        logic [7:0] p0[$];
        logic [7:0] pf[$];
        logic [7:0] fr[$];
        p1 = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h02, 8'h00, 8'h00};
        pf = '{8'h11, 8'h22, 8'h33, 8'h44};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_w_en", {31'd0, w_en}, 32'd0);
        check("rst_w_addr", {19'd0, w_addr}, 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        tick();

        // Pin the model's checksum arithmetic.
        check("model_csum_p1", {24'd0, model_sum(p1)}, 32'h000000CD);
        check("model_csum_pf", {24'd0, model_sum(pf)}, 32'h000000AA);

        load(p1, 8'hCD, 1'b0, -1, "good");
        check("good_last_wdata", last_wdata, 32'h000002B3);
        check("good_last_waddr", {19'd0, last_waddr}, 32'h00000004);
        tick();

        load(p1, 8'hCC, 1'b0, -1, "badsum");
        tick();

        load(p0, 8'h00, 1'b0, -1, "empty");
        repeat (3) tick();

        // Oversize image: N = 2049.
        do_start("oversize");
        fr = '{8'h01, 8'h08};
        send(fr, 1'b0, -1);
        check("oversize_err", {31'd0, err}, 32'd1);
        check("oversize_done", {31'd0, done}, 32'd0);
        check("oversize_ready", {31'd0, in_ready}, 32'd0);
        check("oversize_hold", {31'd0, cpu_hold}, 32'd1);
        repeat (5) tick();

        load(pf, 8'hAA, 1'b1, -1, "flowctl");
        check("flowctl_wdata", last_wdata, 32'h44332211);
        check("flowctl_waddr", {19'd0, last_waddr}, 32'd0);
        tick();

        load(p1, 8'hCD, 1'b0, 3, "start_in_data");
        tick();

        // Reset after two payload bytes: nothing may be written afterwards.
        do_start("midrst");
        fr = '{8'h01, 8'h00, 8'h11, 8'h22};
        send(fr, 1'b0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_hold", {31'd0, cpu_hold}, 32'd1);
        check("midrst_done_err", {31'd0, done || err}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h33;
        repeat (3) tick();
        in_data  = 8'h44;
        repeat (5) tick();
        check("midrst_ready_held", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        tick();

        load(p1, 8'hCD, 1'b0, -1, "after_rst");
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
        $fatal(1, "timeout");
    end

endmodule
